// File: rtl/mem_ctrl.sv
// -----------------------------------------------------------------------------
// mem_ctrl
//   Arbitrates instruction fetch (IF) and load/store (MEM) requests onto the
//   byte-wide memory bus. Each 1/2/4-byte access is serialised into single-byte
//   bus cycles. Read bytes are reassembled little-endian, and loads are zero- or
//   sign-extended. When rdy_in is low the bus is lent to the debug interface and
//   the controller freezes.
//
//   Optional feature: define MEM_CTRL_IF_FLUSH_EN to add the if_flush_in port,
//   which abandons an in-flight fetch.
//
// Ports
//   clk_in, rst_n_in          clock, asynchronous active-low reset
//   rdy_in                    0 = bus lent to HCI, controller frozen
//   if_req_in/if_addr_in      fetch request (always 4 bytes)
//   if_done_out/if_data_out   fetch completion pulse and fetched word
//   mem_req_in, mem_wr_in, mem_size_in, mem_signed_in, mem_addr_in,
//   mem_wdata_in              load/store request fields
//   mem_done_out/mem_rdata_out  load/store completion pulse and load result
//   mem_a, mem_dout, mem_wr   byte bus address, write byte, write strobe
//   mem_din                   read byte (valid the cycle after its address)
//   if_flush_in               (MEM_CTRL_IF_FLUSH_EN only) abandon fetch
//
// States
//   IDLE   | waiting for a request; mem request beats fetch
//   IF_RD  | issuing/capturing the 4 bytes of a fetch
//   MEM_RD | issuing/capturing the 1/2/4 bytes of a load
//   MEM_WR | driving the 1/2/4 write bytes of a store
//   DONE   | registered done pulse; requests ignored for this cycle
// -----------------------------------------------------------------------------
module mem_ctrl #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  rdy_in,
    input  logic                  if_req_in,
    input  logic [ADDR_WIDTH-1:0] if_addr_in,
    output logic                  if_done_out,
    output logic [31:0]           if_data_out,
    input  logic                  mem_req_in,
    input  logic                  mem_wr_in,
    input  logic [1:0]            mem_size_in,
    input  logic                  mem_signed_in,
    input  logic [ADDR_WIDTH-1:0] mem_addr_in,
    input  logic [31:0]           mem_wdata_in,
    output logic                  mem_done_out,
    output logic [31:0]           mem_rdata_out,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic [7:0]            mem_dout,
    input  logic [7:0]            mem_din,
    output logic                  mem_wr
`ifdef MEM_CTRL_IF_FLUSH_EN
    ,
    input  logic                  if_flush_in
`endif
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        IF_RD  = 3'd1,
        MEM_RD = 3'd2,
        MEM_WR = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [2:0]            n_q, n_d;
    logic [1:0]            size_q, size_d;
    logic                  signed_q, signed_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [2:0]            issue_cnt_q, issue_cnt_d;   // bytes addressed so far
    logic [2:0]            cap_cnt_q, cap_cnt_d;       // bytes captured so far
    logic                  avalid_q, avalid_d;         // mem_a holds a live read address
    logic                  dvalid_q, dvalid_d;         // mem_din carries byte cap_cnt_q
    logic [31:0]           buf_q, buf_d;
    logic [ADDR_WIDTH-1:0] mem_a_q, mem_a_d;
    logic [7:0]            mem_dout_q, mem_dout_d;
    logic                  mem_wr_q, mem_wr_d;
    logic                  if_done_q, if_done_d;
    logic                  mem_done_q, mem_done_d;
    logic [31:0]           if_data_q, if_data_d;
    logic [31:0]           mem_rdata_q, mem_rdata_d;

    logic                  flush;
    logic [31:0]           assembled;
    logic [31:0]           load_ext;
    logic [7:0]            wbyte;

`ifdef MEM_CTRL_IF_FLUSH_EN
    assign flush = if_flush_in;
`else
    assign flush = 1'b0;
`endif

    // Word with the byte arriving this cycle merged into its lane.
    always_comb begin
        assembled = buf_q;
        assembled[{cap_cnt_q[1:0], 3'b000} +: 8] = mem_din;
    end

    always_comb begin
        load_ext = assembled;
        case (size_q)
            2'b00:   load_ext = signed_q ? {{24{assembled[7]}}, assembled[7:0]}
                                         : {24'h0, assembled[7:0]};
            2'b01:   load_ext = signed_q ? {{16{assembled[15]}}, assembled[15:0]}
                                         : {16'h0, assembled[15:0]};
            default: load_ext = assembled;
        endcase
    end

    assign wbyte = wdata_q[{issue_cnt_q[1:0], 3'b000} +: 8];

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        n_d         = n_q;
        size_d      = size_q;
        signed_d    = signed_q;
        wdata_d     = wdata_q;
        issue_cnt_d = issue_cnt_q;
        cap_cnt_d   = cap_cnt_q;
        avalid_d    = avalid_q;
        dvalid_d    = dvalid_q;
        buf_d       = buf_q;
        mem_a_d     = mem_a_q;
        mem_dout_d  = mem_dout_q;
        mem_wr_d    = mem_wr_q;
        if_done_d   = if_done_q;
        mem_done_d  = mem_done_q;
        if_data_d   = if_data_q;
        mem_rdata_d = mem_rdata_q;

        case (state_q)
            IDLE: begin
                mem_a_d  = '0;
                mem_wr_d = 1'b0;
                if (rdy_in && mem_req_in) begin
                    base_d      = mem_addr_in;
                    size_d      = mem_size_in;
                    signed_d    = mem_signed_in;
                    wdata_d     = mem_wdata_in;
                    n_d         = (mem_size_in == 2'b00) ? 3'd1 :
                                  (mem_size_in == 2'b01) ? 3'd2 : 3'd4;
                    buf_d       = '0;
                    cap_cnt_d   = 3'd0;
                    issue_cnt_d = 3'd1;
                    mem_a_d     = mem_addr_in;
                    dvalid_d    = 1'b0;
                    if (mem_wr_in) begin
                        state_d    = MEM_WR;
                        mem_wr_d   = 1'b1;
                        mem_dout_d = mem_wdata_in[7:0];
                        avalid_d   = 1'b0;
                    end else begin
                        state_d  = MEM_RD;
                        avalid_d = 1'b1;
                    end
                end else if (rdy_in && if_req_in && !flush) begin
                    base_d      = if_addr_in;
                    size_d      = 2'b10;
                    signed_d    = 1'b0;
                    n_d         = 3'd4;
                    buf_d       = '0;
                    cap_cnt_d   = 3'd0;
                    issue_cnt_d = 3'd1;
                    mem_a_d     = if_addr_in;
                    avalid_d    = 1'b1;
                    dvalid_d    = 1'b0;
                    state_d     = IF_RD;
                end
            end

            IF_RD, MEM_RD: begin
                if (state_q == IF_RD && flush) begin
                    state_d  = IDLE;
                    mem_a_d  = '0;
                    avalid_d = 1'b0;
                    dvalid_d = 1'b0;
                end else if (!rdy_in) begin
                    // Bus is lent out: drop the in-flight byte and park the
                    // address on the first uncaptured byte so it is the one
                    // re-issued when rdy_in returns.
                    dvalid_d    = 1'b0;
                    avalid_d    = 1'b1;
                    mem_a_d     = base_q + ADDR_WIDTH'(cap_cnt_q);
                    issue_cnt_d = cap_cnt_q + 3'd1;
                end else begin
                    dvalid_d = avalid_q;
                    if (issue_cnt_q < n_q) begin
                        mem_a_d     = base_q + ADDR_WIDTH'(issue_cnt_q);
                        issue_cnt_d = issue_cnt_q + 3'd1;
                        avalid_d    = 1'b1;
                    end else begin
                        avalid_d = 1'b0;
                    end
                    if (dvalid_q) begin
                        buf_d     = assembled;
                        cap_cnt_d = cap_cnt_q + 3'd1;
                        if (cap_cnt_q + 3'd1 == n_q) begin
                            state_d  = DONE;
                            mem_a_d  = '0;
                            avalid_d = 1'b0;
                            dvalid_d = 1'b0;
                            if (state_q == IF_RD) begin
                                if_done_d = 1'b1;
                                if_data_d = assembled;
                            end else begin
                                mem_done_d  = 1'b1;
                                mem_rdata_d = load_ext;
                            end
                        end
                    end
                end
            end

            MEM_WR: begin
                // With rdy_in low everything holds, so a masked byte is
                // simply driven again once the bus comes back.
                if (rdy_in) begin
                    if (issue_cnt_q == n_q) begin
                        state_d    = DONE;
                        mem_wr_d   = 1'b0;
                        mem_a_d    = '0;
                        mem_done_d = 1'b1;
                    end else begin
                        mem_a_d     = base_q + ADDR_WIDTH'(issue_cnt_q);
                        mem_dout_d  = wbyte;
                        issue_cnt_d = issue_cnt_q + 3'd1;
                    end
                end
            end

            DONE: begin
                if (rdy_in) begin
                    state_d    = IDLE;
                    if_done_d  = 1'b0;
                    mem_done_d = 1'b0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q     <= IDLE;
            base_q      <= '0;
            n_q         <= 3'd0;
            size_q      <= 2'b00;
            signed_q    <= 1'b0;
            wdata_q     <= '0;
            issue_cnt_q <= 3'd0;
            cap_cnt_q   <= 3'd0;
            avalid_q    <= 1'b0;
            dvalid_q    <= 1'b0;
            buf_q       <= '0;
            mem_a_q     <= '0;
            mem_dout_q  <= 8'h00;
            mem_wr_q    <= 1'b0;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
            if_data_q   <= '0;
            mem_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            n_q         <= n_d;
            size_q      <= size_d;
            signed_q    <= signed_d;
            wdata_q     <= wdata_d;
            issue_cnt_q <= issue_cnt_d;
            cap_cnt_q   <= cap_cnt_d;
            avalid_q    <= avalid_d;
            dvalid_q    <= dvalid_d;
            buf_q       <= buf_d;
            mem_a_q     <= mem_a_d;
            mem_dout_q  <= mem_dout_d;
            mem_wr_q    <= mem_wr_d;
            if_done_q   <= if_done_d;
            mem_done_q  <= mem_done_d;
            if_data_q   <= if_data_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    // The strobe and done pulses are masked while the bus is lent out; the
    // underlying registers hold so they reappear when rdy_in returns.
    assign mem_wr        = mem_wr_q & rdy_in;
    assign if_done_out   = if_done_q & rdy_in;
    assign mem_done_out  = mem_done_q & rdy_in;
    assign mem_a         = mem_a_q;
    assign mem_dout      = mem_dout_q;
    assign if_data_out   = if_data_q;
    assign mem_rdata_out = mem_rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
module tb_mem_ctrl;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        rdy_in;
    logic        if_req_in;
    logic [31:0] if_addr_in;
    logic        if_done_out;
    logic [31:0] if_data_out;
    logic        mem_req_in;
    logic        mem_wr_in;
    logic [1:0]  mem_size_in;
    logic        mem_signed_in;
    logic [31:0] mem_addr_in;
    logic [31:0] mem_wdata_in;
    logic        mem_done_out;
    logic [31:0] mem_rdata_out;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din;
    logic        mem_wr;
`ifdef MEM_CTRL_IF_FLUSH_EN
    logic        if_flush_in;
`endif

    int          n_checks = 0;
    int          n_errors = 0;
    int          extra_done;
    logic [31:0] a_tr [0:31];
    logic [31:0] wr_a [0:15];
    logic [7:0]  wr_d [0:15];
    int          wr_n = 0;

    always #5 clk_in = ~clk_in;

    mem_ctrl dut (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n_in),
        .rdy_in        (rdy_in),
        .if_req_in     (if_req_in),
        .if_addr_in    (if_addr_in),
        .if_done_out   (if_done_out),
        .if_data_out   (if_data_out),
        .mem_req_in    (mem_req_in),
        .mem_wr_in     (mem_wr_in),
        .mem_size_in   (mem_size_in),
        .mem_signed_in (mem_signed_in),
        .mem_addr_in   (mem_addr_in),
        .mem_wdata_in  (mem_wdata_in),
        .mem_done_out  (mem_done_out),
        .mem_rdata_out (mem_rdata_out),
        .mem_a         (mem_a),
        .mem_dout      (mem_dout),
        .mem_din       (mem_din),
        .mem_wr        (mem_wr)
`ifdef MEM_CTRL_IF_FLUSH_EN
        ,
        .if_flush_in   (if_flush_in)
`endif
    );

    // Fixed read contents for the addresses the tests touch.
    function automatic logic [7:0] rom(input logic [31:0] a);
        case (a)
            32'h0000_0100: rom = 8'h13;
            32'h0000_0101: rom = 8'h05;
            32'h0000_0102: rom = 8'h00;
            32'h0000_0103: rom = 8'h00;
            32'h0000_0200: rom = 8'h78;
            32'h0000_0201: rom = 8'h56;
            32'h0000_0202: rom = 8'h34;
            32'h0000_0203: rom = 8'h12;
            32'h0000_0010: rom = 8'h34;
            32'h0000_0011: rom = 8'hF2;
            32'h0000_0080: rom = 8'h80;
            32'h0000_0400: rom = 8'h11;
            32'h0000_0401: rom = 8'h22;
            32'h0000_0402: rom = 8'h33;
            32'h0000_0403: rom = 8'h44;
            32'hFFFF_FFFE: rom = 8'hAA;
            32'hFFFF_FFFF: rom = 8'hBB;
            32'h0000_0000: rom = 8'hCC;
            32'h0000_0001: rom = 8'hDD;
            default:       rom = a[7:0] ^ 8'h5A;
        endcase
    endfunction

    // Synchronous RAM model: data for the address of cycle c appears in c+1.
    always @(posedge clk_in) begin
        mem_din <= rom(mem_a);
        if (mem_wr) begin
            wr_a[wr_n[3:0]] <= mem_a;
            wr_d[wr_n[3:0]] <= mem_dout;
            wr_n            <= wr_n + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One request from cycle A; records mem_a per cycle, first done cycle
    // (99 = never seen), result data and any repeated done pulses.
    task automatic txn(input logic is_mem, input logic wr, input logic [1:0] size,
                       input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                       input int s0, input int slen,
                       output int done_k, output logic [31:0] data);
        logic d;
        done_k     = 99;
        data       = '0;
        extra_done = 0;
        @(negedge clk_in);
        rdy_in = 1'b1;
        if (is_mem) begin
            mem_req_in    = 1'b1;
            mem_wr_in     = wr;
            mem_size_in   = size;
            mem_signed_in = sgn;
            mem_addr_in   = addr;
            mem_wdata_in  = wdata;
        end else begin
            if_req_in  = 1'b1;
            if_addr_in = addr;
        end
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk_in);
            rdy_in = !(k >= s0 && k < s0 + slen);
            #1;
            a_tr[k] = mem_a;
            d = is_mem ? mem_done_out : if_done_out;
            if (d) begin
                if (done_k == 99) begin
                    done_k     = k;
                    data       = is_mem ? mem_rdata_out : if_data_out;
                    mem_req_in = 1'b0;
                    if_req_in  = 1'b0;
                end else begin
                    extra_done++;
                end
            end
            if (done_k != 99 && k >= done_k + 2) break;
        end
        mem_req_in = 1'b0;
        if_req_in  = 1'b0;
        rdy_in     = 1'b1;
    endtask

    int          dk, md, id, w0, ndone;
    logic [31:0] dat, mdat, idat;

    initial begin
        rst_n_in      = 1'b0;
        rdy_in        = 1'b1;
        if_req_in     = 1'b0;
        if_addr_in    = '0;
        mem_req_in    = 1'b0;
        mem_wr_in     = 1'b0;
        mem_size_in   = 2'b00;
        mem_signed_in = 1'b0;
        mem_addr_in   = '0;
        mem_wdata_in  = '0;
`ifdef MEM_CTRL_IF_FLUSH_EN
        if_flush_in   = 1'b0;
`endif
        #2;
        check("rst_mem_a", mem_a, 32'h0);
        check("rst_mem_wr", {31'h0, mem_wr}, 32'h0);
        check("rst_if_done", {31'h0, if_done_out}, 32'h0);
        check("rst_mem_done", {31'h0, mem_done_out}, 32'h0);
        check("rst_if_data", if_data_out, 32'h0);
        check("rst_mem_rdata", mem_rdata_out, 32'h0);
        repeat (2) @(negedge clk_in);
        rst_n_in = 1'b1;

        // Word fetch
        txn(1'b0, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 0, 0, dk, dat);
        check("fetch_a0", a_tr[1], 32'h100);
        check("fetch_a1", a_tr[2], 32'h101);
        check("fetch_a2", a_tr[3], 32'h102);
        check("fetch_a3", a_tr[4], 32'h103);
        check("fetch_done_cyc", dk, 6);
        check("fetch_data", dat, 32'h0000_0513);
        check("fetch_one_pulse", extra_done, 0);

        // Simultaneous fetch + load word: load first, fetch after DONE
        md = 99; id = 99; mdat = '0; idat = '0;
        @(negedge clk_in);
        mem_req_in = 1'b1; mem_wr_in = 1'b0; mem_size_in = 2'b10;
        mem_signed_in = 1'b0; mem_addr_in = 32'h200;
        if_req_in = 1'b1; if_addr_in = 32'h100;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk_in);
            #1;
            a_tr[k] = mem_a;
            if (mem_done_out && md == 99) begin md = k; mdat = mem_rdata_out; mem_req_in = 1'b0; end
            if (if_done_out && id == 99) begin id = k; idat = if_data_out; if_req_in = 1'b0; end
            if (id != 99) break;
        end
        mem_req_in = 1'b0; if_req_in = 1'b0;
        check("arb_mem_done_cyc", md, 6);
        check("arb_mem_data", mdat, 32'h1234_5678);
        check("arb_first_addr", a_tr[1], 32'h200);
        check("arb_fetch_addr", a_tr[8], 32'h100);
        check("arb_fetch_done_cyc", id, 13);
        check("arb_fetch_data", idat, 32'h0000_0513);

        // Store byte
        w0 = wr_n;
        txn(1'b1, 1'b1, 2'b00, 1'b0, 32'h30000, 32'hDEAD_BE41, 0, 0, dk, dat);
        check("sb_done_cyc", dk, 2);
        check("sb_wr_cycles", wr_n - w0, 1);
        check("sb_addr", wr_a[w0[3:0]], 32'h30000);
        check("sb_data", {24'h0, wr_d[w0[3:0]]}, 32'h41);

        // Halfword loads, signed and unsigned; signed byte load
        txn(1'b1, 1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 0, 0, dk, dat);
        check("lh_done_cyc", dk, 4);
        check("lh_data", dat, 32'hFFFF_F234);
        txn(1'b1, 1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 0, 0, dk, dat);
        check("lhu_data", dat, 32'h0000_F234);
        txn(1'b1, 1'b0, 2'b00, 1'b1, 32'h80, 32'h0, 0, 0, dk, dat);
        check("lb_done_cyc", dk, 3);
        check("lb_data", dat, 32'hFFFF_FF80);

        // Fetch with rdy_in low for 3 cycles after byte 1 is addressed
        txn(1'b0, 1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 3, 3, dk, dat);
        check("stall_reissue_addr", a_tr[6], 32'h401);
        check("stall_done_cyc", dk, 10);
        check("stall_data", dat, 32'h4433_2211);

        // rdy_in low during the DONE cycle defers the pulse
        txn(1'b1, 1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 3, 2, dk, dat);
        check("defer_done_cyc", dk, 5);
        check("defer_data", dat, 32'h0000_0034);

        // Store word with a 2-cycle stall in the middle
        w0 = wr_n;
        txn(1'b1, 1'b1, 2'b10, 1'b0, 32'h500, 32'hA1B2_C3D4, 2, 2, dk, dat);
        check("sw_stall_done_cyc", dk, 7);
        check("sw_stall_wr_cycles", wr_n - w0, 4);
        for (int i = 0; i < 4; i++) begin
            w0 = w0 + (i == 0 ? 0 : 1);
            check("sw_stall_addr", wr_a[w0[3:0]], 32'h500 + 32'(i));
        end
        w0 = wr_n - 4;
        check("sw_stall_b0", {24'h0, wr_d[w0[3:0]]}, 32'hD4);
        w0 = wr_n - 1;
        check("sw_stall_b3", {24'h0, wr_d[w0[3:0]]}, 32'hA1);

        // Address wrap
        txn(1'b0, 1'b0, 2'b10, 1'b0, 32'hFFFF_FFFE, 32'h0, 0, 0, dk, dat);
        check("wrap_a0", a_tr[1], 32'hFFFF_FFFE);
        check("wrap_a1", a_tr[2], 32'hFFFF_FFFF);
        check("wrap_a2", a_tr[3], 32'h0);
        check("wrap_a3", a_tr[4], 32'h1);
        check("wrap_data", dat, 32'hDDCC_BBAA);

`ifdef MEM_CTRL_IF_FLUSH_EN
        // Flush a fetch in cycle A+2
        ndone = 0;
        @(negedge clk_in);
        if_req_in = 1'b1; if_addr_in = 32'hFFFF_FFFE;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk_in);
            if (k == 2) begin if_flush_in = 1'b1; if_req_in = 1'b0; end
            else if_flush_in = 1'b0;
            #1;
            a_tr[k] = mem_a;
            if (if_done_out) ndone++;
        end
        check("flush_idle_addr", a_tr[3], 32'h0);
        check("flush_idle_addr2", a_tr[4], 32'h0);
        check("flush_no_done", ndone, 0);
`endif

        // Reset in the middle of a fetch
        @(negedge clk_in);
        if_req_in = 1'b1; if_addr_in = 32'h100;
        repeat (3) @(negedge clk_in);
        rst_n_in = 1'b0;
        if_req_in = 1'b0;
        #1;
        check("midrst_mem_a", mem_a, 32'h0);
        check("midrst_if_data", if_data_out, 32'h0);
        check("midrst_mem_rdata", mem_rdata_out, 32'h0);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        ndone = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk_in);
            #1;
            if (if_done_out || mem_done_out) ndone++;
        end
        check("midrst_no_done", ndone, 0);
        check("midrst_idle_addr", mem_a, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
